// File: rtl/gpp_calc_pkg.sv
// gpp_calc_pkg: shared constants and FSM encoding for the factorial multiply
// responder and its datapath.
//   DATA_W / PROD_W : operand and product widths
//   MUL_STEPS       : shift-add steps per multiply
//   FLAG_*          : bit positions inside the {C,V,N,Z} flag nibble
package gpp_calc_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned MUL_STEPS = 16;
  localparam int unsigned CNT_W     = 5;   // must hold the value MUL_STEPS

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/fact_mul_datapath.sv
// fact_mul_datapath: serial unsigned shift-add multiplier core.
//   clk, rst       : clock, synchronous active-high reset
//   load_i         : latch operands, clear accumulator and step counter
//   step_i         : perform one shift-add step (LSB of multiplier first)
//   a_i, b_i       : multiplicand / multiplier
//   acc_o          : 32-bit accumulated product
//   done_o         : all MUL_STEPS steps have been performed since load
module fact_mul_datapath
  import gpp_calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [PROD_W-1:0] acc_o,
  output logic              done_o
);

  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  // Next-state for the shift-add core; load wins over step.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = PROD_W'(a_i);
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
    done_d = (cnt_d == CNT_W'(MUL_STEPS));
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/fact_mul_responder.sv
// fact_mul_responder: 16x16 multiply responder for the factorial sequencer.
// Accepts a request in IDLE, runs a 16-step serial multiply, then pulses ack
// for one cycle with the low product half and {C,V,N,Z} flags.
//   clk, rst : clock, synchronous active-high reset
//   req      : level-sensitive multiply request (sampled in IDLE only)
//   a, b     : multiplicand / multiplier, latched on acceptance
//   busy     : multiply in progress
//   ack      : one-cycle pulse, res/flags valid
//   res      : low 16 bits of a*b (saturated to 16'hFFFF on carry when
//              FACT_MUL_SAT_EN is defined)
//   flags    : {C,V,N,Z}
// Build option: FACT_MUL_SAT_EN enables result saturation.
module fact_mul_responder
  import gpp_calc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] res,
  output logic [FLAG_W-1:0] flags
);

  mul_state_e        state_q;
  logic              busy_q;
  logic              ack_q;
  logic [DATA_W-1:0] res_q;
  logic [FLAG_W-1:0] flags_q;

  logic              load_c;
  logic              step_c;
  logic [PROD_W-1:0] prod;
  logic              dp_done;
  logic [DATA_W-1:0] res_d;
  logic [FLAG_W-1:0] flags_d;
  logic              carry_c;

  // Accept only in IDLE; step until the datapath reports all steps taken.
  assign load_c = (state_q == ST_IDLE) && req;
  assign step_c = (state_q == ST_BUSY) && !dp_done;

  fact_mul_datapath u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load_i (load_c),
    .step_i (step_c),
    .a_i    (a),
    .b_i    (b),
    .acc_o  (prod),
    .done_o (dp_done)
  );

  // Result and flags from the finished product; N/Z follow the final res.
  always_comb begin
    carry_c = |prod[PROD_W-1:DATA_W];
`ifdef FACT_MUL_SAT_EN
    res_d = carry_c ? {DATA_W{1'b1}} : prod[DATA_W-1:0];
`else
    res_d = prod[DATA_W-1:0];
`endif
    flags_d         = '0;
    flags_d[FLAG_C] = carry_c;
    flags_d[FLAG_V] = (prod > PROD_W'(32'h0000_7FFF));
    flags_d[FLAG_N] = res_d[DATA_W-1];
    flags_d[FLAG_Z] = (res_d == '0);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            state_q <= ST_BUSY;
            busy_q  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (dp_done) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            res_q   <= res_d;
            flags_q <= flags_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign ack   = ack_q;
  assign res   = res_q;
  assign flags = flags_q;

endmodule

// File: doc/fact_mul_responder.md
FACT_MUL_RESPONDER -- requirements
Module: fact_mul_responder

Interface
REQ-001 SHALL have clk, input, 1, sole clock, all state updates on the rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have req, input, 1, multiply request from the factorial sequencer, level-sensitive.
REQ-004 SHALL have a, input, 16, multiplicand: running factorial product (fact_reg).
REQ-005 SHALL have b, input, 16, multiplier: current iteration value (fact_val).
REQ-006 SHALL have busy, output, 1, high while a multiply is in progress.
REQ-007 SHALL have ack, output, 1, one-cycle pulse marking res/flags valid.
REQ-008 SHALL have res, output, 16, low 16 bits of a*b, or the saturated value per REQ-024.
REQ-009 SHALL have flags, output, 4, {C,V,N,Z} at bits [3:0] = C,V,N,Z.

Function
REQ-010 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-011 In IDLE with req=1 at an edge, SHALL latch a and b, clear the 32-bit accumulator and step counter, and enter BUSY.
REQ-012 In BUSY, SHALL perform one unsigned shift-add step per cycle, LSB of latched b first, for exactly 16 steps.
REQ-013 After the 16th step edge, SHALL enter DONE; ack=1 for exactly that one cycle; res and flags SHALL be updated on that same edge.
REQ-014 Latency SHALL be 17 edges from the accepting edge to the edge that makes ack visible, with ack high during cycle 17.
REQ-015 DONE SHALL always return to IDLE on the next edge.
REQ-016 req and changes on a/b during BUSY or DONE SHALL be ignored; computation SHALL use only the latched operands.
REQ-017 req held high through DONE SHALL be re-accepted in IDLE, giving back-to-back operation with one idle cycle between jobs.
REQ-018 res and flags SHALL hold their last value until the next DONE.
REQ-019 Z SHALL be (res==0).
REQ-020 N SHALL be res[15].
REQ-021 C SHALL be (product[31:16]!=0).
REQ-022 V SHALL be (product > 16'h7FFF).
REQ-023 A zero operand SHALL still take the full 16 steps: res=0, Z=1, C=0, V=0.

Configuration
REQ-024 With macro FACT_MUL_SAT_EN defined, SHALL force res=16'hFFFF whenever C=1, with N and Z derived from the saturated res; without it, res SHALL be the truncated low half.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, busy=0, ack=0, res=0, flags=0, accumulator=0 and counter=0, aborting any operation in flight with no ack.
REQ-026 rst SHALL take priority over req and over every FSM transition.

Structure
REQ-027 A shared package gpp_calc_pkg SHALL hold the FSM state encoding, the flag bit index constants (C=3, V=2, N=1, Z=0), DATA_W=16 and MUL_STEPS=16.
REQ-028 SHALL instantiate one sub-module, fact_mul_datapath, containing the accumulator, shifter and counter; the FSM and flag logic SHALL remain in fact_mul_responder.

Verification
REQ-029 Factorial chain, each job started after the previous ack: 5*4 then 20*3 then 60*2 -> res 20, 60, 120; each ack 17 edges after accept; flags 0.
REQ-030 300*300 -> C=1 and V=1; without FACT_MUL_SAT_EN res=24464 (16'h5F90); with it res=16'hFFFF and N=1.
REQ-031 0*1234 -> res=0, Z=1, C=0, ack at edge 17.
REQ-032 rst pulsed at step 8 of 7*9 -> no ack, busy=0, res=0; a new 7*9 request then yields res=63.
REQ-033 req held high with a/b changed mid-BUSY -> result uses the latched operands; next job accepted one cycle after DONE.
REQ-034 40000*2 -> C=1, V=1; without FACT_MUL_SAT_EN res=14464 and N=0.
